// File: rtl/dmem_if.sv
// Request/response bundle between the pipeline and the data-memory stage.
// The master drives the access; the slave returns load data and handshake status.
interface dmem_if;
    logic        Req;
    logic [2:0]  Op;
    logic [31:0] Addr;
    logic [31:0] Wdata;
    logic [31:0] Rdata;
    logic        Busy;
    logic        Done;
    logic        Err;

    modport master (
        output Req, Op, Addr, Wdata,
        input  Rdata, Busy, Done, Err
    );

    modport slave (
        input  Req, Op, Addr, Wdata,
        output Rdata, Busy, Done, Err
    );
endinterface

// File: rtl/dmem_unit.sv
// MIPS data-memory stage: word/half/byte big-endian loads and stores with
// misalignment detection and a programmable wait-state Req/Busy/Done handshake.
module dmem_unit #(
    parameter int unsigned ADDR_BITS   = 10,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic  CLK,
    input  logic  RST,
    dmem_if.slave dmem_io
);
    localparam int unsigned Depth = 2 ** ADDR_BITS;

    localparam logic [2:0] OpLw  = 3'd0;
    localparam logic [2:0] OpLh  = 3'd1;
    localparam logic [2:0] OpLhu = 3'd2;
    localparam logic [2:0] OpLb  = 3'd3;
    localparam logic [2:0] OpLbu = 3'd4;
    localparam logic [2:0] OpSw  = 3'd5;
    localparam logic [2:0] OpSh  = 3'd6;
    localparam logic [2:0] OpSb  = 3'd7;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [2:0]           op_q;
    logic [ADDR_BITS+1:0] addr_q;
    logic [31:0]          wdata_q;
    logic [31:0]          rdata_q, rdata_d;
    logic                 err_q, err_d;
    logic [31:0]          mem_q [Depth];

    logic                 accept;
    logic                 access;
    logic [ADDR_BITS-1:0] idx;
    logic [31:0]          word;
    logic [31:0]          wr_word;
    logic [31:0]          load_val;
    logic [7:0]           lane_byte;
    logic [15:0]          lane_half;
    logic                 misaligned;
    logic                 is_store;

    // Upper address bits only wrap the index; they are intentionally dropped.
    logic unused_addr;
    assign unused_addr = ^dmem_io.Addr[31:ADDR_BITS+2];

    assign idx       = addr_q[ADDR_BITS+1:2];
    assign word      = mem_q[idx];
    assign lane_half = addr_q[1] ? word[15:0] : word[31:16];
    assign is_store  = (op_q == OpSw) || (op_q == OpSh) || (op_q == OpSb);

    always_comb begin
        lane_byte = word[31:24];
        unique case (addr_q[1:0])
            2'd0:    lane_byte = word[31:24];
            2'd1:    lane_byte = word[23:16];
            2'd2:    lane_byte = word[15:8];
            default: lane_byte = word[7:0];
        endcase
    end

    always_comb begin
        misaligned = 1'b0;
        unique case (op_q)
            OpLw, OpSw:        misaligned = |addr_q[1:0];
            OpLh, OpLhu, OpSh: misaligned = addr_q[0];
            default:           misaligned = 1'b0;
        endcase
    end

    // Stores keep the previous Rdata, so the default load value is the held one.
    always_comb begin
        load_val = rdata_q;
        unique case (op_q)
            OpLw:    load_val = word;
            OpLh:    load_val = {{16{lane_half[15]}}, lane_half};
            OpLhu:   load_val = {16'h0000, lane_half};
            OpLb:    load_val = {{24{lane_byte[7]}}, lane_byte};
            OpLbu:   load_val = {24'h000000, lane_byte};
            default: load_val = rdata_q;
        endcase
    end

    always_comb begin
        wr_word = word;
        unique case (op_q)
            OpSw: wr_word = wdata_q;
            OpSh: begin
                if (addr_q[1]) wr_word[15:0]  = wdata_q[15:0];
                else           wr_word[31:16] = wdata_q[15:0];
            end
            OpSb: begin
                unique case (addr_q[1:0])
                    2'd0:    wr_word[31:24] = wdata_q[7:0];
                    2'd1:    wr_word[23:16] = wdata_q[7:0];
                    2'd2:    wr_word[15:8]  = wdata_q[7:0];
                    default: wr_word[7:0]   = wdata_q[7:0];
                endcase
            end
            default: wr_word = word;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        access  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (dmem_io.Req) begin
                    accept  = 1'b1;
                    cnt_d   = 4'(WAIT_STATES);
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    access  = 1'b1;
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        rdata_d = rdata_q;
        err_d   = err_q;
        if (access) begin
            err_d   = misaligned;
            rdata_d = misaligned ? 32'h0 : load_val;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            op_q    <= 3'd0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (accept) begin
                op_q    <= dmem_io.Op;
                addr_q  <= dmem_io.Addr[ADDR_BITS+1:0];
                wdata_q <= dmem_io.Wdata;
            end
        end
    end

    // Contents survive reset; an aborted access never reaches StBusy's final edge.
    always_ff @(posedge CLK) begin
        if (access && is_store && !misaligned) begin
            mem_q[idx] <= wr_word;
        end
    end

    assign dmem_io.Busy  = (state_q != StIdle);
    assign dmem_io.Done  = (state_q == StDone);
    assign dmem_io.Err   = (state_q == StDone) && err_q;
    assign dmem_io.Rdata = rdata_q;
endmodule

// File: tb/tb_dmem_unit.sv
// Bench for dmem_unit: directed scenarios plus random traffic, checked every
// cycle against a transaction-timeline model of memory and handshake.
module tb_dmem_unit;
    localparam int unsigned AB = 10;
    localparam int unsigned WS = 2;

    localparam logic [2:0] LW = 3'd0, LH = 3'd1, LHU = 3'd2, LB = 3'd3;
    localparam logic [2:0] LBU = 3'd4, SW = 3'd5, SH = 3'd6, SB = 3'd7;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    dmem_if bus ();

    dmem_unit #(
        .ADDR_BITS  (AB),
        .WAIT_STATES(WS)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .dmem_io(bus)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Model: accepted request at edge E completes its access at edge E+WS+1.
    logic [31:0] m_mem [2**AB];
    bit          m_active = 1'b0;
    int          e = 0;
    int          m_acc = 0;
    int          m_start = 0;
    int          m_done_edge = 0;
    logic [2:0]  m_op;
    logic [31:0] m_addr, m_wdata;
    logic [31:0] m_rdata = 32'h0;
    bit          m_err = 1'b0;
    bit          chk_en = 1'b0;
    int          dut_done_cnt = 0;
    logic        dut_last_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_access();
        int unsigned idx, b, sh;
        logic [31:0] w, byt, half;
        bit mis;
        idx  = 32'(m_addr[AB+1:2]);
        b    = 32'(m_addr[1:0]);
        w    = m_mem[idx];
        byt  = (w >> (8 * (3 - b))) & 32'hFF;
        half = (w >> (16 * (1 - b / 2))) & 32'hFFFF;
        if (m_op == LW || m_op == SW) mis = (b != 0);
        else if (m_op == LH || m_op == LHU || m_op == SH) mis = (b % 2 != 0);
        else mis = 1'b0;
        m_err = mis;
        if (mis) begin
            m_rdata = 32'h0;
            return;
        end
        case (m_op)
            LW:  m_rdata = w;
            LH:  m_rdata = (half >= 32'h8000) ? half + 32'hFFFF0000 : half;
            LHU: m_rdata = half;
            LB:  m_rdata = (byt >= 32'h80) ? byt + 32'hFFFFFF00 : byt;
            LBU: m_rdata = byt;
            SW:  m_mem[idx] = m_wdata;
            SH: begin
                sh = 16 * (1 - b / 2);
                m_mem[idx] = (w & ~(32'hFFFF << sh)) | ((m_wdata & 32'hFFFF) << sh);
            end
            default: begin
                sh = 8 * (3 - b);
                m_mem[idx] = (w & ~(32'hFF << sh)) | ((m_wdata & 32'hFF) << sh);
            end
        endcase
    endfunction

    function automatic void model_edge();
        e++;
        if (!RST) return;
        if (m_active) begin
            if (e == m_acc) begin
                model_access();
                m_done_edge = e;
            end else if (e == m_acc + 1) begin
                m_active = 1'b0;
            end
        end else if (bus.Req) begin
            m_active = 1'b1;
            m_start  = e;
            m_acc    = e + WS + 1;
            m_op     = bus.Op;
            m_addr   = bus.Addr;
            m_wdata  = bus.Wdata;
        end
    endfunction

    task automatic tick();
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
        #1;
    endtask

    // Per-cycle comparison of every DUT output against the model.
    initial begin
        forever begin
            @(negedge CLK);
            if (chk_en) begin
                check("busy", 32'(bus.Busy), 32'(m_active));
                check("done", 32'(bus.Done), 32'(m_active && e == m_acc));
                check("err", 32'(bus.Err), 32'(m_active && e == m_acc && m_err));
                check("rdata", bus.Rdata, m_rdata);
            end
            if (bus.Done === 1'b1) begin
                dut_done_cnt++;
                dut_last_err = bus.Err;
            end
        end
    end

    // Issue one request from idle; optionally fire stray Req pulses while busy.
    task automatic do_op(input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input bit stray);
        int n;
        dut_last_err = 1'bx;
        bus.Req   = 1'b1;
        bus.Op    = op;
        bus.Addr  = addr;
        bus.Wdata = wdata;
        tick();
        check("accept", 32'(m_active), 32'd1);
        bus.Req   = 1'b0;
        bus.Op    = 3'($urandom);
        bus.Addr  = $urandom;
        bus.Wdata = $urandom;
        n = 0;
        while (m_active && n < 50) begin
            bus.Req = stray ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
            n++;
        end
        bus.Req = 1'b0;
        if (m_active) check("op_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        int d0;
        for (int i = 0; i < 2 ** AB; i++) m_mem[i] = 32'h0;
        bus.Req = 1'b0; bus.Op = 3'd0; bus.Addr = 32'h0; bus.Wdata = 32'h0;
        tick();
        check("rst_busy", 32'(bus.Busy), 32'd0);
        check("rst_done", 32'(bus.Done), 32'd0);
        check("rst_rdata", bus.Rdata, 32'h0);
        RST = 1'b1;
        chk_en = 1'b1;
        tick();

        // 1: basic store/load and latency
        do_op(SW, 32'h10, 32'h12345678, 1'b0);
        check("t1_latency", 32'(m_done_edge - m_start), 32'd3);
        check("t1_err", 32'(dut_last_err), 32'd0);
        do_op(LW, 32'h10, 32'h0, 1'b0);
        check("t1_lw", bus.Rdata, 32'h12345678);

        // 2: extensions and lane selection
        do_op(SW, 32'h10, 32'h80FF7F01, 1'b0);
        do_op(LB, 32'h10, 32'h0, 1'b0);   check("t2_lb10", bus.Rdata, 32'hFFFFFF80);
        do_op(LBU, 32'h10, 32'h0, 1'b0);  check("t2_lbu10", bus.Rdata, 32'h00000080);
        do_op(LH, 32'h10, 32'h0, 1'b0);   check("t2_lh10", bus.Rdata, 32'hFFFF80FF);
        do_op(LHU, 32'h12, 32'h0, 1'b0);  check("t2_lhu12", bus.Rdata, 32'h00007F01);
        do_op(LB, 32'h13, 32'h0, 1'b0);   check("t2_lb13", bus.Rdata, 32'h00000001);

        // 3: partial stores
        do_op(SW, 32'h10, 32'h12345678, 1'b0);
        do_op(SB, 32'h11, 32'h000000AB, 1'b0);
        do_op(LW, 32'h10, 32'h0, 1'b0);   check("t3_sb", bus.Rdata, 32'h12AB5678);
        do_op(SH, 32'h12, 32'h0000BEEF, 1'b0);
        do_op(LW, 32'h10, 32'h0, 1'b0);   check("t3_sh", bus.Rdata, 32'h12ABBEEF);

        // 4: misalignment
        do_op(SW, 32'h20, 32'h01020304, 1'b0);
        do_op(SW, 32'h22, 32'hDEADBEEF, 1'b0);
        check("t4_sw_err", 32'(dut_last_err), 32'd1);
        do_op(LW, 32'h20, 32'h0, 1'b0);   check("t4_lw", bus.Rdata, 32'h01020304);
        do_op(LH, 32'h11, 32'h0, 1'b0);
        check("t4_lh_err", 32'(dut_last_err), 32'd1);
        check("t4_lh_rdata", bus.Rdata, 32'h0);

        // 5: address wrap, and Req during BUSY ignored
        do_op(SW, 32'h1010, 32'hCAFEF00D, 1'b0);
        do_op(LW, 32'h0010, 32'h0, 1'b0); check("t5_wrap", bus.Rdata, 32'hCAFEF00D);
        do_op(SW, 32'h54, 32'h0BADF00D, 1'b0);
        d0 = dut_done_cnt;
        bus.Req = 1'b1; bus.Op = SW; bus.Addr = 32'h50; bus.Wdata = 32'h99999999;
        tick();
        bus.Req = 1'b1; bus.Op = SW; bus.Addr = 32'h54; bus.Wdata = 32'h77777777;
        tick();
        bus.Req = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check("t5_one_done", 32'(dut_done_cnt - d0), 32'd1);
        do_op(LW, 32'h54, 32'h0, 1'b0);   check("t5_ignored", bus.Rdata, 32'h0BADF00D);

        // 6: asynchronous reset aborts a pending store
        do_op(SW, 32'h40, 32'h11112222, 1'b0);
        do_op(LW, 32'h40, 32'h0, 1'b0);
        bus.Req = 1'b1; bus.Op = SW; bus.Addr = 32'h40; bus.Wdata = 32'h55AA55AA;
        tick();
        bus.Req = 1'b0;
        d0 = dut_done_cnt;
        RST = 1'b0;
        m_active = 1'b0;
        m_rdata  = 32'h0;
        m_err    = 1'b0;
        #1;
        check("t6_busy", 32'(bus.Busy), 32'd0);
        check("t6_done", 32'(bus.Done), 32'd0);
        check("t6_err", 32'(bus.Err), 32'd0);
        check("t6_rdata", bus.Rdata, 32'h0);
        for (int i = 0; i < 4; i++) tick();
        RST = 1'b1;
        tick();
        check("t6_no_done", 32'(dut_done_cnt - d0), 32'd0);
        do_op(LW, 32'h40, 32'h0, 1'b0);   check("t6_old", bus.Rdata, 32'h11112222);

        // Random traffic over 16 words with random upper address bits
        for (int i = 0; i < 16; i++) do_op(SW, 32'(i * 4), $urandom, 1'b0);
        for (int i = 0; i < 300; i++) begin
            do_op(3'($urandom), $urandom & 32'hFFFFF03F, $urandom, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dmem_unit.md
Name: dmem_unit

Overview:
Parametrised MIPS data-memory stage; successor to the single-cycle LW/SW data memory. Supports word, halfword and byte loads and stores, with sign or zero extension, big-endian lane selection and misalignment detection. A configurable wait-state counter and a Req/Busy/Done handshake prepare the pipeline for slower memories. Sits between the ALU result (byte address) and the writeback mux.

Parameters:
ADDR_BITS, 10, word-index width; depth = 2**ADDR_BITS 32-bit words.
WAIT_STATES, 0, extra cycles before the access is performed (0..15).

Ports:
CLK  in  1  clock; all state updates on rising edge.
RST  in  1  reset: asynchronous, active-low (RST=0 resets immediately).
Req  in  1  access request; sampled only in IDLE.
Op  in  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101 SW, 110 SH, 111 SB.
Addr  in  32  byte address (ALU Result).
Wdata  in  32  store data; SH uses [15:0], SB uses [7:0].
Rdata  out  32  load result, extended to 32 bits.
Busy  out  1  high whenever state != IDLE.
Done  out  1  one-cycle pulse: the access has completed.
Err  out  1  misalignment flag; valid only while Done=1.

Behaviour:
- Reset (RST=0, async): state=IDLE, counter=0, Rdata=0, Busy=0, Done=0, Err=0. Memory contents are not cleared by RST. Memory initialises to all-zero at simulation start.
- Word index = Addr[ADDR_BITS+1:2]. Upper address bits are ignored, so addresses wrap modulo depth.
- Byte order is big-endian. Addr[1:0]=0 selects bits [31:24] and 3 selects [7:0]. A halfword at Addr[1]=0 is [31:16]; at Addr[1]=1 it is [15:0].
- Alignment rules:
  - LW/SW require Addr[1:0]=0.
  - LH/LHU/SH require Addr[0]=0.
  - LB/LBU/SB are always aligned.
- FSM states are IDLE, BUSY and DONE.
  - IDLE: if Req=1 at an edge, latch Op/Addr/Wdata, load counter=WAIT_STATES and go to BUSY. Otherwise stay in IDLE.
  - BUSY: if counter!=0, decrement it. If counter==0, perform the access on that edge and go to DONE.
  - DONE: Done=1 for exactly this cycle, then return to IDLE.
- Latency: if Req is accepted at edge E, the access occurs at edge E+WAIT_STATES+1 and Done is high in the cycle after it. Back-to-back throughput is one access per WAIT_STATES+3 cycles.
- Req while Busy=1 (BUSY or DONE) is ignored; it is not queued. Inputs are latched at acceptance, so later changes have no effect.
- Store: write only the addressed byte lanes (read-modify-write of the word); other lanes are unchanged. Rdata is unchanged.
- Load: Rdata <= extended value, registered at the access edge. It holds until the next completed load or reset.
  - LH/LB sign-extend; LHU/LBU zero-extend.
- Misaligned access: no memory write, Rdata <= 0, Err=1 during Done. Latency is the same as an aligned access.
- Aligned access: Err=0 during Done. Err=0 whenever Done=0.
- Reset asserted mid-operation aborts the access: a pending store is not written and no Done pulse occurs.

Test Plan:
1. ADDR_BITS=10, WAIT_STATES=2. Req SW 0x12345678 @0x10 at edge E -> Done high after edge E+3, Err=0. Then LW @0x10 -> Rdata=0x12345678.
2. SW 0x80FF7F01 @0x10, then:
   - LB @0x10 -> 0xFFFFFF80
   - LBU @0x10 -> 0x00000080
   - LH @0x10 -> 0xFFFF80FF
   - LHU @0x12 -> 0x00007F01
   - LB @0x13 -> 0x00000001
3. Over 0x12345678 @0x10: SB 0x000000AB @0x11 -> LW gives 0x12AB5678. Then SH 0x0000BEEF @0x12 -> LW gives 0x12ABBEEF.
4. Misaligned: SW 0xDEADBEEF @0x22 -> Err=1 with Done, and LW @0x20 still returns the prior value. LH @0x11 -> Err=1, Rdata=0x00000000.
5. Wrap and ignored Req: SW 0xCAFEF00D @0x1010 -> LW @0x0010 returns 0xCAFEF00D. A Req pulse during BUSY is ignored: no second Done, no access.
6. RST=0 in the cycle after SW 0x55AA55AA @0x40 is accepted:
   - Busy, Done, Err and Rdata go to 0 without waiting for CLK.
   - No Done pulse occurs.
   - After release, LW @0x40 returns the old value.
